lpd: RTL and testbench

LPD -- requirements
Module: LPD

---
 rtl/lpd.sv | 79 +++++++
 tb/tb_lpd.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lpd.sv
// Two-word pattern detector: scans a 1024-word stream by address, flags PAT_A
// followed by PAT_B and counts hits. Define LPD_COUNT_SAT_EN to saturate the count at 15.
module lpd #(
  parameter logic [9:0] PAT_A = 10'h2A5,
  parameter logic [9:0] PAT_B = 10'h15A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] data,
  output logic [9:0] addr,
  output logic       flag,
  output logic [3:0] count,
  output logic       fin
);

  localparam logic [0:0] ST_SCAN = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  logic [0:0] state_q, state_d;
  logic [9:0] addr_q, addr_d;
  logic [9:0] prev_q, prev_d;
  logic       prev_valid_q, prev_valid_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] count_sum;
  logic       scanning;
  logic       last_word;
  logic       hit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    cnt_d        = cnt_q;

    scanning  = (state_q == ST_SCAN);
    last_word = (addr_q == 10'd1023);
    // Gating with scanning first keeps flag clean while data floats after the scan.
    hit = rst_n & scanning & prev_valid_q & (prev_q == PAT_A) & (data == PAT_B);

`ifdef LPD_COUNT_SAT_EN
    count_sum = (cnt_q == 4'hF) ? 4'hF : cnt_q + {3'b000, hit};
`else
    count_sum = cnt_q + {3'b000, hit};
`endif

    if (scanning) begin
      addr_d       = last_word ? addr_q : addr_q + 10'd1;
      state_d      = last_word ? ST_DONE : ST_SCAN;
      prev_d       = data;
      prev_valid_d = 1'b1;
      cnt_d        = count_sum;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SCAN;
      addr_q       <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign addr  = addr_q;
  assign fin   = (state_q == ST_DONE);
  assign flag  = hit;
  assign count = rst_n ? count_sum : 4'h0;

endmodule

// File: tb/tb_lpd.sv
// Self-checking bench for lpd: memory-backed stream, array-based reference of
// expected per-address hits and running totals.
module tb_lpd;

  localparam logic [9:0] PA = 10'h2A5;
  localparam logic [9:0] PB = 10'h15A;

  logic       clk;
  logic       rst_n;
  logic [9:0] data;
  logic [9:0] addr;
  logic       flag;
  logic [3:0] count;
  logic       fin;

  logic [9:0] mem [1024];
  logic       zdrive;
  bit         exp_flag [1024];
  int         exp_cnt  [1024];

  int checks = 0;
  int errors = 0;

  lpd #(.PAT_A(PA), .PAT_B(PB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .addr  (addr),
    .flag  (flag),
    .count (count),
    .fin   (fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    data = mem[addr];
    if (zdrive) data = 'z;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Displayed count from a raw hit total, following the configured overflow rule.
  function automatic int shown(input int hits);
`ifdef LPD_COUNT_SAT_EN
    return (hits > 15) ? 15 : hits;
`else
    return hits % 16;
`endif
  endfunction

  task automatic build_model();
    int hits = 0;
    for (int i = 0; i < 1024; i++) begin
      exp_flag[i] = (i > 0) && (mem[i-1] == PA) && (mem[i] == PB);
      if (exp_flag[i]) hits++;
      exp_cnt[i] = shown(hits);
    end
  endtask

  task automatic clear_mem(input logic [9:0] fill);
    for (int i = 0; i < 1024; i++) mem[i] = fill;
  endtask

  // Called between edges; asserts reset, checks async effect, releases on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_addr",  addr,  0);
    check("rst_fin",   fin,   0);
    check("rst_count", count, 0);
    check("rst_flag",  flag,  0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scans from addr 0; stop_at < 1024 abandons the scan at that address with a reset.
  task automatic run_scan(input string name, input int stop_at);
    build_model();
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      #1;
      check({name, "_addr"},  addr,  i);
      check({name, "_fin"},   fin,   0);
      check({name, "_flag"},  flag,  exp_flag[i]);
      check({name, "_count"}, count, exp_cnt[i]);
      if (i == stop_at) return;
      @(negedge clk);
    end
    #1;
    check({name, "_end_fin"},   fin,   1);
    check({name, "_end_addr"},  addr,  1023);
    check({name, "_end_flag"},  flag,  0);
    check({name, "_end_count"}, count, exp_cnt[1023]);
    zdrive = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check({name, "_hold_fin"},   fin,   1);
      check({name, "_hold_addr"},  addr,  1023);
      check({name, "_hold_flag"},  flag,  0);
      check({name, "_hold_count"}, count, exp_cnt[1023]);
    end
    zdrive = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    zdrive = 1'b0;
    clear_mem(10'h000);
    @(negedge clk);

    // All-zero stream.
    run_scan("zero", 1024);

    // Single pair at 10/11.
    clear_mem(10'h000);
    mem[10] = PA; mem[11] = PB;
    run_scan("pair", 1024);
    check("pair_total", exp_cnt[1023], 1);

    // Address-0 B, overlap A,A,B, broken A,X,B, back-to-back A,B,A,B.
    clear_mem(10'h000);
    mem[0] = PB;
    mem[100] = PA; mem[101] = PA; mem[102] = PB;
    mem[200] = PA; mem[201] = 10'h001; mem[202] = PB;
    mem[300] = PA; mem[301] = PB; mem[302] = PA; mem[303] = PB;
    run_scan("seq", 1024);
    check("seq_total", exp_cnt[1023], 3);

    // Twenty pairs: overflow behaviour.
    clear_mem(10'h000);
    for (int k = 0; k < 20; k++) begin
      mem[400 + 2*k] = PA;
      mem[401 + 2*k] = PB;
    end
    run_scan("ovf", 1024);
`ifdef LPD_COUNT_SAT_EN
    check("ovf_total", exp_cnt[1023], 15);
`else
    check("ovf_total", exp_cnt[1023], 4);
`endif

    // Reset mid-scan at addr 500 with three hits, then a full rescan.
    clear_mem(10'h000);
    for (int k = 0; k < 3; k++) begin
      mem[50 + 10*k] = PA;
      mem[51 + 10*k] = PB;
    end
    mem[700] = PA; mem[701] = PB;
    run_scan("abort", 500);
    check("abort_cnt_at_500", exp_cnt[500], 3);
    run_scan("rescan", 1024);

    // Hit in the very last word, then Z data after fin.
    clear_mem(10'h000);
    mem[1022] = PA; mem[1023] = PB;
    run_scan("last", 1024);

    // Random streams dense with pattern words.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 1024; i++) begin
        case ($urandom_range(0, 3))
          0:       mem[i] = PA;
          1:       mem[i] = PB;
          default: mem[i] = 10'($urandom);
        endcase
      end
      run_scan("rand", 1024);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
